// File: rtl/param_paritysel_mux.sv
// -----------------------------------------------------------------------------
// param_paritysel_mux
//
// Registered 2:1 data multiplexer steered by the parity of a select word.
// The XOR-reduction of i_sel picks the source. With ODD_SELECTS_B=1, even
// parity picks i_data_a and odd parity picks i_data_b; ODD_SELECTS_B=0 swaps
// the two. The selected word leaves one clock later, together with a valid
// flag, its own parity bit and the parity of the select word that chose it.
//
// Parameters:
//   WIDTH          data width, 1..1024
//   SEL_WIDTH      select word width, 1..32
//   ODD_SELECTS_B  1: odd select parity picks B; 0: odd select parity picks A
//
// Ports:
//   i_clk          rising-edge clock for all state
//   i_rst          synchronous active-high reset
//   i_in_valid     qualifies i_sel, i_data_a and i_data_b this cycle
//   i_sel          select word; its XOR-reduction chooses the source
//   i_data_a       source A
//   i_data_b       source B
//   o_data_out     registered selected data
//   o_out_valid    one-cycle pulse per accepted input, aligned with o_data_out
//   o_out_parity   XOR-reduction of o_data_out, registered alongside it
//   o_sel_parity   XOR-reduction of the i_sel that produced o_data_out
// -----------------------------------------------------------------------------
module param_paritysel_mux #(
  parameter int WIDTH         = 8,
  parameter int SEL_WIDTH     = 4,
  parameter int ODD_SELECTS_B = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  input  logic [SEL_WIDTH-1:0] i_sel,
  input  logic [WIDTH-1:0]     i_data_a,
  input  logic [WIDTH-1:0]     i_data_b,
  output logic [WIDTH-1:0]     o_data_out,
  output logic                 o_out_valid,
  output logic                 o_out_parity,
  output logic                 o_sel_parity
);

  // Any non-zero value means "odd parity steers to B".
  localparam logic L_ODD_B = (ODD_SELECTS_B != 0);

  logic             w_sel_parity;
  logic             w_pick_b;
  logic [WIDTH-1:0] w_data_sel;
  logic             w_data_parity;

  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_out_parity;
  logic             r_sel_parity;

  assign w_sel_parity = ^i_sel;

  // B is taken when the select parity equals the "odd" polarity for B.
  assign w_pick_b      = (w_sel_parity == L_ODD_B);
  assign w_data_sel    = w_pick_b ? i_data_b : i_data_a;

  // Parity is taken from the selected word before the register so that it is
  // always coherent with o_data_out.
  assign w_data_parity = ^w_data_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out   <= '0;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
      r_sel_parity <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      // Data and parity bits hold across idle cycles.
      if (i_in_valid) begin
        r_data_out   <= w_data_sel;
        r_out_parity <= w_data_parity;
        r_sel_parity <= w_sel_parity;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_out_valid  = r_out_valid;
  assign o_out_parity = r_out_parity;
  assign o_sel_parity = r_sel_parity;

endmodule

// File: tb/tb_param_paritysel_mux.sv
// -----------------------------------------------------------------------------
// tb_param_paritysel_mux
//
// Four instances: the default configuration (driven by directed vectors) and
// three ODD_SELECTS_B=0 variants with WIDTH 1, 13 and 32 (driven randomly).
// A reference model follows the select rules at every rising edge; a single
// negedge process compares every instance against it.
// -----------------------------------------------------------------------------
module tb_param_paritysel_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8, SEL_WIDTH=4, ODD_SELECTS_B=1
  logic       iv0 = 1'b0;
  logic [3:0] sel0 = '0;
  logic [7:0] da0 = '0, db0 = '0, do0;
  logic       ov0, op0, sp0;
  // Instance 1: WIDTH=1, SEL_WIDTH=4, ODD_SELECTS_B=0
  logic       iv1 = 1'b0;
  logic [3:0] sel1 = '0;
  logic [0:0] da1 = '0, db1 = '0, do1;
  logic       ov1, op1, sp1;
  // Instance 2: WIDTH=13, SEL_WIDTH=7, ODD_SELECTS_B=0
  logic        iv2 = 1'b0;
  logic [6:0]  sel2 = '0;
  logic [12:0] da2 = '0, db2 = '0, do2;
  logic        ov2, op2, sp2;
  // Instance 3: WIDTH=32, SEL_WIDTH=4, ODD_SELECTS_B=0
  logic        iv3 = 1'b0;
  logic [3:0]  sel3 = '0;
  logic [31:0] da3 = '0, db3 = '0, do3;
  logic        ov3, op3, sp3;

  param_paritysel_mux #(.WIDTH(8), .SEL_WIDTH(4), .ODD_SELECTS_B(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv0), .i_sel(sel0),
    .i_data_a(da0), .i_data_b(db0), .o_data_out(do0), .o_out_valid(ov0),
    .o_out_parity(op0), .o_sel_parity(sp0));
  param_paritysel_mux #(.WIDTH(1), .SEL_WIDTH(4), .ODD_SELECTS_B(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv1), .i_sel(sel1),
    .i_data_a(da1), .i_data_b(db1), .o_data_out(do1), .o_out_valid(ov1),
    .o_out_parity(op1), .o_sel_parity(sp1));
  param_paritysel_mux #(.WIDTH(13), .SEL_WIDTH(7), .ODD_SELECTS_B(0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv2), .i_sel(sel2),
    .i_data_a(da2), .i_data_b(db2), .o_data_out(do2), .o_out_valid(ov2),
    .o_out_parity(op2), .o_sel_parity(sp2));
  param_paritysel_mux #(.WIDTH(32), .SEL_WIDTH(4), .ODD_SELECTS_B(0)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv3), .i_sel(sel3),
    .i_data_a(da3), .i_data_b(db3), .o_data_out(do3), .o_out_valid(ov3),
    .o_out_parity(op3), .o_sel_parity(sp3));

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_d [4];
  bit          m_v [4];
  bit          m_p [4];
  bit          m_sp[4];
  bit          model_live = 1'b0;

  // Count set bits of the select word; odd count means odd parity.
  task automatic model_step(input int i, input bit v, input logic [31:0] s,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit odd_picks_b);
    bit odd;
    if (rst) begin
      m_d[i] = '0; m_v[i] = 0; m_p[i] = 0; m_sp[i] = 0;
    end else if (v) begin
      odd     = ($countones(s) % 2) == 1;
      m_d[i]  = (odd == odd_picks_b) ? b : a;
      m_p[i]  = ($countones(m_d[i]) % 2) == 1;
      m_sp[i] = odd;
      m_v[i]  = 1;
    end else begin
      m_v[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_live = 1'b1;
    model_step(0, iv0, 32'(sel0), 32'(da0), 32'(db0), 1'b1);
    model_step(1, iv1, 32'(sel1), 32'(da1), 32'(db1), 1'b0);
    model_step(2, iv2, 32'(sel2), 32'(da2), 32'(db2), 1'b0);
    model_step(3, iv3, 32'(sel3), 32'(da3), 32'(db3), 1'b0);
  end

  always @(posedge clk) begin
    if (iv0) assert (!$isunknown(sel0)) else $error("sel0 unknown while valid");
    if (iv1) assert (!$isunknown(sel1)) else $error("sel1 unknown while valid");
    if (iv2) assert (!$isunknown(sel2)) else $error("sel2 unknown while valid");
    if (iv3) assert (!$isunknown(sel3)) else $error("sel3 unknown while valid");
  end

  task automatic cmp_inst(input int i, input logic [31:0] d, input logic v,
                          input logic p, input logic sp);
    check($sformatf("m%0d_data", i),  d,        m_d[i]);
    check($sformatf("m%0d_valid", i), 32'(v),   32'(m_v[i]));
    check($sformatf("m%0d_opar", i),  32'(p),   32'(m_p[i]));
    check($sformatf("m%0d_spar", i),  32'(sp),  32'(m_sp[i]));
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp_inst(0, 32'(do0), ov0, op0, sp0);
      cmp_inst(1, 32'(do1), ov1, op1, sp1);
      cmp_inst(2, 32'(do2), ov2, op2, sp2);
      cmp_inst(3, 32'(do3), ov3, op3, sp3);
    end
  end

  // ---------------- directed stimulus (instance 0) ----------------
  // Drive at negedge, let one rising edge pass, land on the next negedge.
  task automatic cycle0(input bit v, input logic [3:0] s,
                        input logic [7:0] a, input logic [7:0] b);
    iv0 = v; sel0 = s; da0 = a; db0 = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit0(input string name, input logic [7:0] d, input bit v,
                      input bit p, input bit sp);
    check({name, "_data"},  32'(do0), 32'(d));
    check({name, "_valid"}, 32'(ov0), 32'(v));
    check({name, "_opar"},  32'(op0), 32'(p));
    check({name, "_spar"},  32'(sp0), 32'(sp));
  endtask

  initial begin
    // Variants sit on a fixed vector while the directed part runs.
    iv1 = 1; sel1 = 4'b0001; da1 = 1'b1;          db1 = 1'b0;
    iv2 = 1; sel2 = 7'h01;   da2 = 13'h1ABC;      db2 = 13'h0123;
    iv3 = 1; sel3 = 4'b0001; da3 = 32'hDEADBEEF;  db3 = 32'h12345678;

    rst = 1;
    @(negedge clk);
    cycle0(0, 4'b0000, 8'h00, 8'h00);
    lit0("reset", 8'h00, 0, 0, 0);
    rst = 0;

    cycle0(1, 4'b0010, 8'h55, 8'hAA);
    lit0("odd_b", 8'hAA, 1, 0, 1);
    // Odd select under ODD_SELECTS_B=0 picks A in the variants.
    check("w1_odd_a",  32'(do1), 32'h1);
    check("w32_odd_a", 32'(do3), 32'hDEADBEEF);
    check("w32_opar",  32'(op3), 32'h0);
    check("w13_odd_a", 32'(do2), 32'h1ABC);

    cycle0(1, 4'b0011, 8'h55, 8'hAA);
    lit0("even_a", 8'h55, 1, 0, 0);
    cycle0(1, 4'b0111, 8'h55, 8'hAA);
    lit0("odd3_b", 8'hAA, 1, 0, 1);

    cycle0(1, 4'b0001, 8'h55, 8'h07);
    lit0("b07", 8'h07, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cycle0(0, 4'b0001, 8'h55, 8'hFF);
      lit0($sformatf("hold%0d", k), 8'h07, 0, 1, 1);
    end

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        cycle0(1, 4'b0000, 8'h0F, 8'hF0);
        lit0($sformatf("b2b%0d", k), 8'h0F, 1, 0, 0);
      end else begin
        cycle0(1, 4'b1000, 8'h0F, 8'hF0);
        lit0($sformatf("b2b%0d", k), 8'hF0, 1, 0, 1);
      end
    end

    rst = 1;
    cycle0(1, 4'b1000, 8'h0F, 8'hF0);
    lit0("rst_prio", 8'h00, 0, 0, 0);
    rst = 0;
    cycle0(1, 4'b0100, 8'h3C, 8'hC3);
    lit0("post_rst", 8'hC3, 1, 0, 1);

    // ---------------- random sweep (all instances) ----------------
    for (int n = 0; n < 1000; n++) begin
      iv0 = ($urandom_range(0, 9) < 8); sel0 = 4'($urandom);
      da0 = 8'($urandom);               db0 = 8'($urandom);
      iv1 = ($urandom_range(0, 9) < 8); sel1 = 4'($urandom);
      da1 = 1'($urandom);               db1 = 1'($urandom);
      iv2 = ($urandom_range(0, 9) < 8); sel2 = 7'($urandom);
      da2 = 13'($urandom);              db2 = 13'($urandom);
      iv3 = ($urandom_range(0, 9) < 8); sel3 = 4'($urandom);
      da3 = $urandom;                   db3 = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/param_paritysel_mux.md
Name: param_paritysel_mux

Overview:
- Parameterised 2:1 data multiplexer whose select is the parity of a 4-bit select word, not a single select bit.
- Even parity of sel routes data_a; odd parity routes data_b.
- Output is registered, with a valid flag and an output parity bit, so it can sit as a pipeline stage in a datapath where a control field steers between two operand sources.

Parameters:
- WIDTH, 8, data width in bits of data_a, data_b and data_out; legal range 1 to 1024.
- SEL_WIDTH, 4, width of the select word; legal range 1 to 32.
- ODD_SELECTS_B, 1, when 1 odd sel parity picks data_b; when 0 the mapping is inverted (odd picks data_a).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- in_valid  input  1  qualifies sel, data_a and data_b in the current cycle.
- sel  input  SEL_WIDTH  select word; its XOR-reduction chooses the source.
- data_a  input  WIDTH  source A.
- data_b  input  WIDTH  source B.
- data_out  output  WIDTH  registered selected data.
- out_valid  output  1  high for one cycle per accepted input, aligned with data_out.
- out_parity  output  1  XOR-reduction of data_out (even-parity bit of the word), registered with data_out.
- sel_parity  output  1  registered XOR-reduction of the sel that produced the current data_out.

Behaviour:
- Select parity:
  - p = XOR of all SEL_WIDTH bits of sel.
  - With ODD_SELECTS_B=1: p=0 selects data_a, p=1 selects data_b.
  - With ODD_SELECTS_B=0 the mapping is swapped.
- Latency is exactly 1 clock. Inputs sampled at rising edge N with in_valid=1 appear on all outputs after edge N, valid for the cycle N to N+1.
- Reset (rst=1 at a rising edge):
  - data_out=0, out_valid=0, out_parity=0, sel_parity=0.
  - rst has priority over in_valid in the same cycle.
  - Reset mid-stream discards the in-flight word; nothing is emitted for it.
- No input accepted (in_valid=0 at an edge, rst=0):
  - out_valid goes 0.
  - data_out, out_parity and sel_parity hold their previous values.
- Back-to-back operation: in_valid may stay high every cycle. Each cycle produces a new word; there is no bubble and no backpressure.
- out_parity is computed from the selected word before registering, so it always matches data_out in the same cycle.
- Data is passed unmodified: no truncation or extension; width equals WIDTH exactly.
- Select changes between cycles take effect on the next accepted word only. There is no combinational path from any input to any output.
- X or Z on sel while in_valid=1 is illegal. The bench flags it with an assertion; RTL behaviour is then unspecified.
- After reset deasserts, the first accepted word follows normally with the 1-cycle latency.

Test Plan:
- Reset then steady state: rst=1 for 2 cycles -> data_out=0x00, out_valid=0, out_parity=0, sel_parity=0.
- Odd parity picks B (WIDTH=8, defaults): data_a=0x55, data_b=0xAA, sel=4'b0010, in_valid=1 -> next cycle data_out=0xAA, sel_parity=1, out_parity=0, out_valid=1.
- Even parity picks A: same data, sel=4'b0011 -> next cycle data_out=0x55, sel_parity=0, out_parity=0. Then sel=4'b0111 (odd) -> data_out=0xAA.
- Hold and valid gap: accept sel=4'b0001, data_b=0x07 -> data_out=0x07, out_parity=1. Then in_valid=0 for 3 cycles with data_b=0xFF -> data_out stays 0x07, out_valid=0.
- Back-to-back with reset priority:
  - Alternate sel 4'b0000 and 4'b1000 every cycle with data_a=0x0F, data_b=0xF0 -> data_out alternates 0x0F and 0xF0 with out_valid held high.
  - Assert rst together with in_valid -> outputs zero next cycle.
- Parameter sweep: WIDTH=1, 13 and 32 with ODD_SELECTS_B=0, random sel/data for 1000 cycles -> data_out matches a reference model, out_parity equals the XOR of data_out every valid cycle, and odd parity selects data_a.
